data_ram_responder: RTL and testbench

Responder end of the core's data-memory port: services the `data_ram_*` requests issued by the pipeline's MEM stage. It provides a synchronous, byte-writable word RAM with one-cycle read latency, plus a small memory-mapped register window holding LEDs, switches, a free-running cycle counter and a compare timer with an interrupt flag. It sits at the top level beside the CPU, wired directly to its data-port outputs.

---
 rtl/data_ram_responder_if.sv | 25 ++
 rtl/data_ram_responder.sv | 137 +++++++++++++
 tb/tb_data_ram_responder.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_ram_responder_if.sv
// Data-memory port between the pipeline MEM stage (master) and the RAM/MMIO responder (slave).
// data_ram_ena acts as valid; the responder is always ready, so every enabled request is accepted on the edge it is presented and its read data appears on data_ram_r_data after that edge.
interface data_ram_responder_if;
  logic        data_ram_ena;
  logic [3:0]  data_ram_wea;
  logic [31:0] data_ram_addr;
  logic [31:0] data_ram_w_data;
  logic [31:0] data_ram_r_data;

  modport master (
    output data_ram_ena,
    output data_ram_wea,
    output data_ram_addr,
    output data_ram_w_data,
    input  data_ram_r_data
  );

  modport slave (
    input  data_ram_ena,
    input  data_ram_wea,
    input  data_ram_addr,
    input  data_ram_w_data,
    output data_ram_r_data
  );
endinterface

// File: rtl/data_ram_responder.sv
// Byte-writable read-first word RAM with one-cycle read latency, plus an optional register
// window (LED, SW, CYCLE, CMP, STATUS) compiled in when DATA_RAM_MMIO_EN is defined.
module data_ram_responder #(
  parameter int          ADDR_WIDTH   = 12,
  parameter logic [15:0] MMIO_BASE_HI = 16'hBFAF
) (
  input  logic                 clk,
  input  logic                 rst,
  data_ram_responder_if.slave  bus,
  input  logic [15:0]          sw,
  output logic [15:0]          led,
  output logic                 timer_irq
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0]           mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  req_ok;
  logic                  mmio_sel;
  logic [31:0]           mmio_rd;
  logic [3:0]            lane_we;
  logic [31:0]           r_data_d;
  logic [31:0]           r_data_q;

  assign word_idx = bus.data_ram_addr[ADDR_WIDTH+1:2];
  // A request presented while reset is high is dropped entirely.
  assign req_ok   = bus.data_ram_ena && !rst;
  assign lane_we  = (req_ok && !mmio_sel) ? bus.data_ram_wea : 4'h0;

`ifdef DATA_RAM_MMIO_EN
  localparam logic [15:0] OFF_LED    = 16'h0000;
  localparam logic [15:0] OFF_SW     = 16'h0004;
  localparam logic [15:0] OFF_CYCLE  = 16'h0008;
  localparam logic [15:0] OFF_CMP    = 16'h000C;
  localparam logic [15:0] OFF_STATUS = 16'h0010;

  logic [15:0] offset;
  logic        reg_wr;
  logic        match;
  logic [15:0] led_d;
  logic [15:0] led_q;
  logic [31:0] cycle_d;
  logic [31:0] cycle_q;
  logic [31:0] cmp_d;
  logic [31:0] cmp_q;
  logic        flag_d;
  logic        flag_q;

  assign mmio_sel = (bus.data_ram_addr[31:16] == MMIO_BASE_HI);
  assign offset   = bus.data_ram_addr[15:0];
  assign reg_wr   = req_ok && mmio_sel && (bus.data_ram_wea == 4'hF);
  assign match    = (cycle_q == cmp_q);

  always_comb begin
    mmio_rd = '0;
    case (offset)
      OFF_LED:    mmio_rd = {16'h0000, led_q};
      OFF_SW:     mmio_rd = {16'h0000, sw};
      OFF_CYCLE:  mmio_rd = cycle_q;
      OFF_CMP:    mmio_rd = cmp_q;
      OFF_STATUS: mmio_rd = {31'h0, flag_q};
      default:    mmio_rd = '0;
    endcase
  end

  // A register write overrides the free-running increment; a match set beats a STATUS clear.
  always_comb begin
    led_d   = led_q;
    cycle_d = cycle_q + 32'd1;
    cmp_d   = cmp_q;
    flag_d  = flag_q | match;
    if (reg_wr) begin
      case (offset)
        OFF_LED:    led_d   = bus.data_ram_w_data[15:0];
        OFF_CYCLE:  cycle_d = bus.data_ram_w_data;
        OFF_CMP:    cmp_d   = bus.data_ram_w_data;
        OFF_STATUS: flag_d  = match | (flag_q & ~bus.data_ram_w_data[0]);
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q   <= '0;
      cycle_q <= '0;
      cmp_q   <= 32'hFFFF_FFFF;
      flag_q  <= 1'b0;
    end else begin
      led_q   <= led_d;
      cycle_q <= cycle_d;
      cmp_q   <= cmp_d;
      flag_q  <= flag_d;
    end
  end

  assign led       = led_q;
  assign timer_irq = flag_q;
`else
  logic unused_ok;

  assign mmio_sel  = 1'b0;
  assign mmio_rd   = '0;
  assign led       = '0;
  assign timer_irq = 1'b0;
  assign unused_ok = ^{MMIO_BASE_HI, sw, bus.data_ram_addr[31:ADDR_WIDTH+2],
                       bus.data_ram_addr[1:0]};
`endif

  always_comb begin
    r_data_d = r_data_q;
    if (req_ok) begin
      r_data_d = mmio_sel ? mmio_rd : mem_q[word_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_q <= '0;
    end else begin
      r_data_q <= r_data_d;
    end
  end

  // Read-first: r_data_d samples the old word before this edge's lane updates land.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (lane_we[i]) begin
        mem_q[word_idx][8*i +: 8] <= bus.data_ram_w_data[8*i +: 8];
      end
    end
  end

  assign bus.data_ram_r_data = r_data_q;

endmodule

// File: tb/tb_data_ram_responder.sv
// Directed and randomized bench for data_ram_responder with a word-array/arithmetic reference model.
`timescale 1ns/1ps
module tb_data_ram_responder;
  localparam int          AW = 12;
  localparam logic [15:0] HI = 16'hBFAF;
`ifdef DATA_RAM_MMIO_EN
  localparam bit MMIO = 1'b1;
`else
  localparam bit MMIO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sw;
  logic [15:0] led;
  logic        timer_irq;

  data_ram_responder_if bus();

  data_ram_responder #(.ADDR_WIDTH(AW), .MMIO_BASE_HI(HI)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .sw        (sw),
    .led       (led),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  // Reference model state.
  logic [31:0] ram_m [0:(1<<AW)-1];
  logic [31:0] exp_r;
  logic [15:0] exp_led;
  logic [31:0] exp_cmp;
  logic        exp_flag;
  logic [31:0] cyc_base;
  longint      edges     = 0;
  longint      base_edge = 0;

  int          idx_tab [16] = '{0, 1, 2, 3, 5, 7, 16, 32, 100, 511, 1024, 2047, 4090, 4093, 4094, 4095};
  logic [15:0] off_tab [7]  = '{16'h0000, 16'h0004, 16'h0008, 16'h000C, 16'h0010, 16'h0014, 16'h0100};

  // CYCLE counts edges since the last reset or CYCLE write, modulo 2^32.
  function automatic logic [31:0] cur_cycle();
    return cyc_base + 32'(edges - base_edge);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic en, input logic [3:0] we,
                      input logic [31:0] a, input logic [31:0] d);
    logic [31:0] c;
    logic        set_f;
    logic        nf;
    int          idx;
    rst                 = r;
    bus.data_ram_ena    = en;
    bus.data_ram_wea    = we;
    bus.data_ram_addr   = a;
    bus.data_ram_w_data = d;
    c = cur_cycle();
    if (r) begin
      exp_r     = '0;
      exp_led   = '0;
      exp_cmp   = 32'hFFFF_FFFF;
      exp_flag  = 1'b0;
      cyc_base  = '0;
      base_edge = edges + 1;
    end else begin
      set_f = MMIO && (c == exp_cmp);
      nf    = exp_flag | set_f;
      if (en && MMIO && (a[31:16] == HI)) begin
        case (a[15:0])
          16'h0000: exp_r = {16'h0000, exp_led};
          16'h0004: exp_r = {16'h0000, sw};
          16'h0008: exp_r = c;
          16'h000C: exp_r = exp_cmp;
          16'h0010: exp_r = {31'h0, exp_flag};
          default:  exp_r = '0;
        endcase
        if (we == 4'hF) begin
          case (a[15:0])
            16'h0000: exp_led = d[15:0];
            16'h0008: begin cyc_base = d; base_edge = edges + 1; end
            16'h000C: exp_cmp = d;
            16'h0010: if (d[0]) nf = set_f;
            default:  ;
          endcase
        end
      end else if (en) begin
        idx   = int'(a[AW+1:2]);
        exp_r = ram_m[idx];
        for (int i = 0; i < 4; i++) begin
          if (we[i]) ram_m[idx][8*i +: 8] = d[8*i +: 8];
        end
      end
      exp_flag = nf;
    end
    @(posedge clk);
    edges++;
    #1;
    chk("r_data", bus.data_ram_r_data, exp_r);
    chk("led", {16'h0000, led}, {16'h0000, exp_led});
    chk("timer_irq", {31'h0, timer_irq}, {31'h0, exp_flag});
  endtask

  function automatic logic [31:0] waddr(input int idx);
    return {18'h0, 12'(idx), 2'b00};
  endfunction

  initial begin
    logic [31:0] a;
    logic [17:0] hi;
    logic [3:0]  we;
    logic [31:0] saved;
    int          idx;

    sw = 16'h0000;
    step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("reset_rdata", bus.data_ram_r_data, 32'h0);
    chk("reset_led", {16'h0, led}, 32'h0);
    chk("reset_irq", {31'h0, timer_irq}, 32'h0);

`ifdef DATA_RAM_MMIO_EN
    // Timer: CMP=20 written in the first cycle after reset.
    step(1'b0, 1'b1, 4'hF, {HI, 16'h000C}, 32'd20);
    for (int i = 0; i < 19; i++) step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("irq_before_match", {31'h0, timer_irq}, 32'h0);
    step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("irq_at_match", {31'h0, timer_irq}, 32'h1);
    step(1'b0, 1'b1, 4'hF, {HI, 16'h0010}, 32'h1);
    chk("irq_cleared", {31'h0, timer_irq}, 32'h0);
    // Set and clear on the same edge: set wins.
    step(1'b0, 1'b1, 4'hF, {HI, 16'h000C}, cur_cycle() + 32'd1);
    step(1'b0, 1'b1, 4'hF, {HI, 16'h0010}, 32'h1);
    chk("set_beats_clear", {31'h0, timer_irq}, 32'h1);
    step(1'b0, 1'b1, 4'hF, {HI, 16'h0010}, 32'h1);
    chk("irq_cleared2", {31'h0, timer_irq}, 32'h0);
    // Counter wrap.
    step(1'b0, 1'b1, 4'hF, {HI, 16'h0008}, 32'hFFFF_FFFE);
    step(1'b0, 1'b1, 4'h0, {HI, 16'h0008}, 32'h0);
    chk("cycle_written", bus.data_ram_r_data, 32'hFFFF_FFFE);
    step(1'b0, 1'b1, 4'h0, {HI, 16'h0008}, 32'h0);
    chk("cycle_max", bus.data_ram_r_data, 32'hFFFF_FFFF);
    step(1'b0, 1'b1, 4'h0, {HI, 16'h0008}, 32'h0);
    chk("cycle_wrap", bus.data_ram_r_data, 32'h0000_0000);
`endif

    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 4'hF, waddr(idx_tab[i]), $urandom);
    end

    // Byte lanes.
    step(1'b0, 1'b1, 4'hF, 32'h0000_0040, 32'h1234_5678);
    step(1'b0, 1'b1, 4'b0010, 32'h0000_0040, 32'h0000_AB00);
    step(1'b0, 1'b1, 4'h0, 32'h0000_0040, 32'h0);
    chk("lane_merge", bus.data_ram_r_data, 32'h1234_AB78);

    // Read-first collision.
    step(1'b0, 1'b1, 4'hF, 32'h0000_0080, 32'h0000_0011);
    step(1'b0, 1'b1, 4'hF, 32'h0000_0080, 32'h0000_0022);
    chk("read_first_old", bus.data_ram_r_data, 32'h0000_0011);
    step(1'b0, 1'b1, 4'h0, 32'h0000_0080, 32'h0);
    chk("read_after_write", bus.data_ram_r_data, 32'h0000_0022);
    step(1'b0, 1'b0, 4'h0, 32'h0000_0040, 32'h0);
    chk("hold_when_idle", bus.data_ram_r_data, 32'h0000_0022);

`ifdef DATA_RAM_MMIO_EN
    step(1'b0, 1'b1, 4'hF, {HI, 16'h0000}, 32'h0000_A5A5);
    chk("led_write", {16'h0, led}, 32'h0000_A5A5);
    step(1'b0, 1'b1, 4'b0011, {HI, 16'h0000}, 32'h0000_FFFF);
    chk("led_partial_ignored", {16'h0, led}, 32'h0000_A5A5);
    sw = 16'h0F0F;
    step(1'b0, 1'b1, 4'h0, {HI, 16'h0004}, 32'h0);
    chk("sw_read", bus.data_ram_r_data, 32'h0000_0F0F);
    step(1'b0, 1'b1, 4'h0, {HI, 16'h0100}, 32'h0);
    chk("unmapped_read", bus.data_ram_r_data, 32'h0);
    step(1'b1, 1'b1, 4'hF, {HI, 16'h0000}, 32'h0000_FFFF);
    chk("reset_during_led_write", {16'h0, led}, 32'h0);
`else
    step(1'b0, 1'b1, 4'hF, 32'hBFAF_0000, 32'hA5A5_1234);
    step(1'b0, 1'b1, 4'h0, 32'h0000_0000, 32'h0);
    chk("alias_to_ram", bus.data_ram_r_data, 32'hA5A5_1234);
    chk("led_tied_low", {16'h0, led}, 32'h0);
`endif

    // Reset during a RAM write leaves the word untouched.
    saved = ram_m[5];
    step(1'b0, 1'b1, 4'h0, waddr(7), 32'h0);
    step(1'b1, 1'b1, 4'hF, waddr(5), ~saved);
    chk("reset_during_ram_write", bus.data_ram_r_data, 32'h0);
    step(1'b0, 1'b1, 4'h0, waddr(5), 32'h0);
    chk("ram_unchanged_by_reset", bus.data_ram_r_data, saved);

    for (int n = 0; n < 400; n++) begin
      sw  = 16'($urandom);
      idx = idx_tab[$urandom_range(0, 15)];
      if (MMIO && ($urandom_range(0, 3) == 0)) begin
        a = {HI, off_tab[$urandom_range(0, 6)]};
      end else begin
        hi = 18'($urandom);
        if (hi[17:2] == HI) hi[17] = ~hi[17];
        a = {hi, 12'(idx), 2'($urandom)};
      end
      case ($urandom_range(0, 2))
        0:       we = 4'h0;
        1:       we = 4'hF;
        default: we = 4'($urandom);
      endcase
      step(1'b0, ($urandom_range(0, 4) != 0), we, a, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
